grf: RTL and testbench
======================

GRF -- requirements
Module: grf

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning: 1 forwards the same-cycle write data to the read ports; 0 returns the stored value only.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port raddr1, input, 5, read port 1 register index.
REQ-005 SHALL have port raddr2, input, 5, read port 2 register index.
REQ-006 SHALL have port rdata1, output, 32, read port 1 data (combinational).
REQ-007 SHALL have port rdata2, output, 32, read port 2 data (combinational).
REQ-008 SHALL have port we, input, 1, write request for the current cycle.
REQ-009 SHALL have port waddr, input, 5, write register index.
REQ-010 SHALL have port wdata, input, 32, write data.
REQ-011 SHALL have port pc, input, 32, PC of the instruction issuing the write (trace only).
REQ-012 SHALL have port trace_valid, output, 1, one-cycle pulse after each write request.
REQ-013 SHALL have port trace_pc, output, 32, registered pc of the traced write.
REQ-014 SHALL have port trace_addr, output, 5, registered waddr of the traced write.
REQ-015 SHALL have port trace_data, output, 32, value actually committed by the traced write.
REQ-016 SHALL have port wr_count, output, 32, count of committed writes to registers 1..31.

Function
REQ-017 SHALL hold 32 registers of 32 bits; register 0 is hardwired to 0 and never stored.
REQ-018 SHALL derive a 32-bit one-hot write-enable vector from waddr, all zero when we=0.
REQ-019 SHALL write wdata into register waddr on the rising clk edge when we=1 and waddr!=0; all other registers hold.
REQ-020 SHALL ignore writes when we=1 and waddr=0; register 0 stays 0.
REQ-021 SHALL drive rdataN=0 whenever raddrN=0, regardless of we, waddr and BYPASS.
REQ-022 SHALL drive rdataN=wdata when BYPASS=1, we=1, waddr=raddrN and raddrN!=0; otherwise rdataN is the stored register value.
REQ-023 SHALL have a read latency of zero (combinational) and a write latency of one edge, so a BYPASS=0 read returns the new value in the cycle after the write.
REQ-024 SHALL let both read ports address the same register simultaneously, with identical results.
REQ-025 SHALL register trace_valid=1, trace_pc=pc, trace_addr=waddr and trace_data=(waddr==0 ? 0 : wdata) on each edge with we=1, including waddr=0.
REQ-026 SHALL register trace_valid=0 on each edge with we=0; trace_pc, trace_addr and trace_data hold their previous values.
REQ-027 SHALL increment wr_count by 1 on each edge with we=1 and waddr!=0, wrapping from 0xFFFFFFFF to 0.
REQ-028 SHALL update on every consecutive edge for back-to-back writes to the same register, with no stall; the last write wins.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, force registers 1..31 to 0, trace_valid to 0, trace_pc to 0, trace_addr to 0, trace_data to 0 and wr_count to 0.
REQ-030 SHALL discard a write whose edge coincides with asserted reset, with no trace pulse and no count.
REQ-031 SHALL keep the combinational read path live during reset, returning 0 for stored registers; with BYPASS=1 the bypass still applies.

Structure
REQ-032 SHALL place the constants REG_COUNT=32, REG_AW=5 and DATA_W=32 in the shared CPU package, used by this block and the datapath.
REQ-033 SHALL instantiate one sub-module, grf_wdec, a 5-to-32 one-hot write-enable decoder gated by we.
REQ-034 SHALL contain no other sub-modules; storage, bypass, trace and counter live in grf.

Verification
REQ-035 SHALL cover: reset, then write 0x12345678 to reg 8 with pc 0x00003000 -> next cycle rdata1(raddr1=8)=0x12345678; trace_valid=1, trace_pc=0x00003000, trace_addr=8, trace_data=0x12345678; wr_count=1.
REQ-036 SHALL cover: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1(raddr1=0)=0 both same-cycle and after the edge; trace_valid=1 with trace_data=0; wr_count unchanged.
REQ-037 SHALL cover: BYPASS=1, reg 5 = 0xA, same-cycle write of 0xB to reg 5 with raddr1=raddr2=5 -> both read 0xB; with BYPASS=0 both read 0xA until the edge.
REQ-038 SHALL cover: writes to all regs 1..31 with value = index*0x01010101, then read every pair -> each matches its value; wr_count=31.
REQ-039 SHALL cover: reset asserted mid-cycle between edges after reg 3 = 0x55 -> rdata(raddr=3)=0 immediately, trace_valid=0, wr_count=0; a write on the reset edge is not committed.
REQ-040 SHALL cover: wr_count forced to 0xFFFFFFFF via 2^32-1 writes (or a backdoor preload) plus one write -> wr_count=0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared CPU constants and the trace record layout used by the general register file.
package grf_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_rec_t;

    function automatic logic addr_is_zero(input logic [REG_AW-1:0] addr);
        return (addr == {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/grf_wdec.sv
// One-hot write-enable decoder: asserts exactly one bit for waddr when we=1, else none.
module grf_wdec
    import grf_pkg::*;
(
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    output logic [REG_COUNT-1:0] wen
);

    // Decode the write index into a one-hot enable vector gated by we.
    always_comb begin
        wen = {REG_COUNT{1'b0}};
        if (we) begin
            wen[waddr] = 1'b1;
        end else begin
            wen = {REG_COUNT{1'b0}};
        end
    end

endmodule

// File: rtl/grf.sv
// 32x32 general register file: two combinational read ports with optional write bypass,
// one write port, a registered write-trace record and a committed-write counter.
module grf
    import grf_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] pc,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_pc,
    output logic [REG_AW-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [DATA_W-1:0] wr_count
);

    logic [REG_COUNT-1:0] wen_s;
    logic                 commit_s;
    logic [DATA_W-1:0]    regs_r [1:REG_COUNT-1];
    logic [DATA_W-1:0]    rdata1_s;
    logic [DATA_W-1:0]    rdata2_s;
    trace_rec_t           trace_r;
    logic                 trace_valid_r;
    logic [DATA_W-1:0]    wr_count_r;

    grf_wdec u_wdec (
        .we    (we),
        .waddr (waddr),
        .wen   (wen_s)
    );

    // Bit 0 of the enable vector marks a discarded write to the zero register.
    assign commit_s = |wen_s[REG_COUNT-1:1];

    // Register storage; register 0 has no flops and reads as a constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (wen_s[i]) begin
                    regs_r[i] <= wdata;
                end
            end
        end
    end

    // Read port 1: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        rdata1_s = {DATA_W{1'b0}};
        if (addr_is_zero(raddr1)) begin
            rdata1_s = {DATA_W{1'b0}};
        end else if (BYPASS && we && (waddr == raddr1)) begin
            rdata1_s = wdata;
        end else begin
            rdata1_s = regs_r[raddr1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rdata2_s = {DATA_W{1'b0}};
        if (addr_is_zero(raddr2)) begin
            rdata2_s = {DATA_W{1'b0}};
        end else if (BYPASS && we && (waddr == raddr2)) begin
            rdata2_s = wdata;
        end else begin
            rdata2_s = regs_r[raddr2];
        end
    end

    // Trace record: pulses for every write request, payload holds between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_valid_r <= 1'b0;
            trace_r       <= '{pc: {DATA_W{1'b0}}, addr: {REG_AW{1'b0}}, data: {DATA_W{1'b0}}};
        end else begin
            trace_valid_r <= we;
            if (we) begin
                trace_r.pc   <= pc;
                trace_r.addr <= waddr;
                trace_r.data <= wen_s[0] ? {DATA_W{1'b0}} : wdata;
            end
        end
    end

    // Committed-write counter; wraps naturally at the top of its range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_r <= {DATA_W{1'b0}};
        end else if (commit_s) begin
            wr_count_r <= wr_count_r + 32'd1;
        end
    end

    assign rdata1      = rdata1_s;
    assign rdata2      = rdata2_s;
    assign trace_valid = trace_valid_r;
    assign trace_pc    = trace_r.pc;
    assign trace_addr  = trace_r.addr;
    assign trace_data  = trace_r.data;
    assign wr_count    = wr_count_r;

endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf: one bypassing and one non-bypassing instance share inputs.
module tb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  raddr1, raddr2, waddr;
    logic        we;
    logic [31:0] wdata, pc;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        tv_b, tv_n;
    logic [31:0] tpc_b, tpc_n, tdata_b, tdata_n, cnt_b, cnt_n;
    logic [4:0]  taddr_b, taddr_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grf #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_b), .rdata2(rd2_b), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
        .trace_valid(tv_b), .trace_pc(tpc_b), .trace_addr(taddr_b), .trace_data(tdata_b),
        .wr_count(cnt_b)
    );

    grf #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_n), .rdata2(rd2_n), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
        .trace_valid(tv_n), .trace_pc(tpc_n), .trace_addr(taddr_n), .trace_data(tdata_n),
        .wr_count(cnt_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        we = 1'b1; waddr = a; wdata = d; pc = p;
        edge_step();
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] v1, v2;
        reset = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; pc = 32'd0;
        raddr1 = 5'd8; raddr2 = 5'd8;
        edge_step();
        chk("reset_tv", {31'd0, tv_b}, 32'd0);
        chk("reset_cnt", cnt_b, 32'd0);
        chk("reset_tpc", tpc_b, 32'd0);
        chk("reset_rd", rd1_n, 32'd0);
        edge_step();
        reset = 1'b0;

        // Basic write to reg 8
        we = 1'b1; waddr = 5'd8; wdata = 32'h12345678; pc = 32'h00003000; raddr1 = 5'd8;
        #1;
        chk("pre_edge_nobyp", rd1_n, 32'd0);
        chk("pre_edge_byp", rd1_b, 32'h12345678);
        edge_step();
        we = 1'b0;
        #1;
        chk("w8_rd", rd1_n, 32'h12345678);
        chk("w8_tv", {31'd0, tv_n}, 32'd1);
        chk("w8_tpc", tpc_n, 32'h00003000);
        chk("w8_taddr", {27'd0, taddr_n}, 32'd8);
        chk("w8_tdata", tdata_n, 32'h12345678);
        chk("w8_cnt", cnt_n, 32'd1);
        edge_step();
        chk("idle_tv", {31'd0, tv_b}, 32'd0);
        chk("idle_tdata_hold", tdata_b, 32'h12345678);
        chk("idle_tpc_hold", tpc_b, 32'h00003000);

        // Write to register 0 is traced but discarded
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; pc = 32'h00003004; raddr1 = 5'd0;
        #1;
        chk("r0_same_cycle", rd1_b, 32'd0);
        edge_step();
        we = 1'b0;
        #1;
        chk("r0_after", rd1_b, 32'd0);
        chk("r0_tv", {31'd0, tv_b}, 32'd1);
        chk("r0_tdata", tdata_b, 32'd0);
        chk("r0_taddr", {27'd0, taddr_b}, 32'd0);
        chk("r0_cnt", cnt_b, 32'd1);

        // Bypass vs stored read, both ports on the same register
        do_write(5'd5, 32'h0000000A, 32'h00003008);
        we = 1'b1; waddr = 5'd5; wdata = 32'h0000000B; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        chk("byp_rd1", rd1_b, 32'h0000000B);
        chk("byp_rd2", rd2_b, 32'h0000000B);
        chk("nobyp_rd1", rd1_n, 32'h0000000A);
        chk("nobyp_rd2", rd2_n, 32'h0000000A);
        edge_step();
        we = 1'b0;
        #1;
        chk("nobyp_after", rd1_n, 32'h0000000B);
        chk("cnt_after_byp", cnt_n, 32'd3);

        // Back-to-back writes to one register, last write wins
        do_write(5'd7, 32'd1, 32'h10);
        we = 1'b1; wdata = 32'd2; edge_step();
        wdata = 32'd3; edge_step();
        we = 1'b0;
        raddr1 = 5'd7;
        #1;
        chk("b2b_rd", rd1_n, 32'd3);
        chk("b2b_cnt", cnt_n, 32'd6);

        // Mid-cycle reset after reg 3 = 0x55
        do_write(5'd3, 32'h00000055, 32'h20);
        raddr1 = 5'd3;
        #1;
        chk("r3_before_reset", rd1_n, 32'h00000055);
        reset = 1'b1;
        #1;
        chk("rst_rd3", rd1_n, 32'd0);
        chk("rst_tv", {31'd0, tv_n}, 32'd0);
        chk("rst_cnt", cnt_n, 32'd0);
        we = 1'b1; waddr = 5'd4; wdata = 32'h00000099; raddr1 = 5'd4;
        #1;
        chk("rst_bypass_live", rd1_b, 32'h00000099);
        edge_step();
        we = 1'b0;
        #1;
        chk("rst_edge_rd4", rd1_n, 32'd0);
        chk("rst_edge_tv", {31'd0, tv_n}, 32'd0);
        chk("rst_edge_cnt", cnt_n, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_rd4", rd1_b, 32'd0);

        // Fill all registers, then read every pair
        for (int i = 1; i < 32; i++) begin
            v1 = 32'h01010101 * i;
            do_write(i[4:0], v1, 32'h4000 + i);
        end
        for (int i = 1; i < 32; i++) begin
            raddr1 = i[4:0];
            raddr2 = 5'(32 - i);
            v1 = 32'h01010101 * i;
            v2 = 32'h01010101 * (32 - i);
            #1;
            chk($sformatf("fill_rd1_%0d", i), rd1_n, v1);
            chk($sformatf("fill_rd2_%0d", i), rd2_n, v2);
        end
        chk("fill_cnt", cnt_n, 32'd31);

        // Counter wrap from a preloaded all-ones value
        @(negedge clk);
        force dut.wr_count_r = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_r;
        #1;
        chk("wrap_preload", cnt_b, 32'hFFFFFFFF);
        do_write(5'd9, 32'h0000ABCD, 32'h5000);
        #1;
        chk("wrap_cnt", cnt_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
